// File: rtl/decode_trace_sequencer.sv
// decode_trace_sequencer
// Buffers decoded-instruction descriptors and walks each one through the
// trace print order (mnemonic, operand0, separator, operand1, end-of-line).
// It emits one formatting token per cycle to the trace formatter.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. The producer holds valid and all payload stable until that
// edge. The consumer may raise or drop ready freely. Here that means
// in_valid/in_ready on the descriptor side and tok_valid/tok_ready on the
// token side. tok_valid is only withdrawn without acceptance by flush or
// reset_n.
module decode_trace_sequencer #(
   parameter int DEPTH = 4,
   parameter int TAG_W = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [TAG_W-1:0] in_tag,
   input  logic [5:0]       in_op0,
   input  logic [5:0]       in_op1,
   output logic             tok_valid,
   input  logic             tok_ready,
   output logic [3:0]       tok_code,
   output logic             tok_opd,
   output logic [TAG_W-1:0] tok_tag,
   output logic             tok_last,
   output logic [2:0]       dbg_state
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

   // Token codes seen by the formatter
   localparam logic [3:0] TOK_MNEM   = 4'd0;
   localparam logic [3:0] TOK_REG    = 4'd1;
   localparam logic [3:0] TOK_IMM    = 4'd2;
   localparam logic [3:0] TOK_DISP   = 4'd3;
   localparam logic [3:0] TOK_LPAREN = 4'd4;
   localparam logic [3:0] TOK_BASE   = 4'd5;
   localparam logic [3:0] TOK_COMMA  = 4'd6;
   localparam logic [3:0] TOK_INDEX  = 4'd7;
   localparam logic [3:0] TOK_SCALE  = 4'd8;
   localparam logic [3:0] TOK_RPAREN = 4'd9;
   localparam logic [3:0] TOK_SEP    = 4'd10;
   localparam logic [3:0] TOK_EOL    = 4'd11;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_MNEM = 3'd1,
      S_OPD0 = 3'd2,
      S_SEP  = 3'd3,
      S_OPD1 = 3'd4,
      S_EOL  = 3'd5
   } state_t;

   // Next token chosen by the planner: where the FSM goes and what it shows
   typedef struct packed {
      state_t     state;
      logic [2:0] step;
      logic [3:0] code;
      logic       opd;
      logic       last;
   } plan_t;

   // Operand flags: [5:4] type (0 nil, 1 reg, 2 imm, 3 mem),
   // [3] has_disp, [2] has_base, [1] has_index, [0] has_scale.
   // Memory sub-steps: 0 DISP, 1 LPAREN, 2 BASE, 3 COMMA, 4 INDEX,
   // 5 COMMA, 6 SCALE, 7 RPAREN. Reg/imm use step 0 only.
   function automatic logic step_en(input logic [5:0] op, input logic [2:0] step);
      logic en;
      en = 1'b0;
      case (op[5:4])
         2'd1, 2'd2: en = (step == 3'd0);
         2'd3: begin
            case (step)
               3'd0:       en = op[3];
               3'd1:       en = 1'b1;
               3'd2:       en = op[2];
               3'd3:       en = op[1] | op[0];
               3'd4:       en = op[1];
               3'd5, 3'd6: en = op[0];
               default:    en = 1'b1;
            endcase
         end
         default: en = 1'b0;
      endcase
      return en;
   endfunction

   function automatic logic [3:0] step_code(input logic [5:0] op, input logic [2:0] step);
      logic [3:0] code;
      code = TOK_RPAREN;
      if (op[5:4] == 2'd1) begin
         code = TOK_REG;
      end else if (op[5:4] == 2'd2) begin
         code = TOK_IMM;
      end else begin
         case (step)
            3'd0:    code = TOK_DISP;
            3'd1:    code = TOK_LPAREN;
            3'd2:    code = TOK_BASE;
            3'd3:    code = TOK_COMMA;
            3'd4:    code = TOK_INDEX;
            3'd5:    code = TOK_COMMA;
            3'd6:    code = TOK_SCALE;
            default: code = TOK_RPAREN;
         endcase
      end
      return code;
   endfunction

   // First enabled sub-step at or after start; 8 means the operand is done
   function automatic logic [3:0] find_step(input logic [5:0] op, input logic [3:0] start);
      logic [3:0] found;
      logic [3:0] s;
      found = 4'd8;
      for (int i = 7; i >= 0; i--) begin
         s = 4'(i);
         if ((s >= start) && step_en(op, s[2:0])) begin
            found = s;
         end
      end
      return found;
   endfunction

   // Walk forward from a phase/sub-step and return the next token to emit.
   // Skipped pieces fall straight through, so they cost no cycles.
   function automatic plan_t plan_next(input logic [5:0] op0, input logic [5:0] op1,
                                       input state_t phase, input logic [3:0] start);
      plan_t      p;
      state_t     ph;
      logic [3:0] st;
      logic [3:0] s;
      logic       done;
      p.state = S_EOL;
      p.step  = 3'd0;
      p.code  = TOK_EOL;
      p.opd   = 1'b0;
      p.last  = 1'b1;
      ph      = phase;
      st      = start;
      done    = 1'b0;
      if (ph == S_OPD0) begin
         s = find_step(op0, st);
         if (!s[3]) begin
            p.state = S_OPD0;
            p.step  = s[2:0];
            p.code  = step_code(op0, s[2:0]);
            p.last  = 1'b0;
            done    = 1'b1;
         end else begin
            ph = S_SEP;
            st = 4'd0;
         end
      end
      if (!done && ph == S_SEP) begin
         if ((op0[5:4] != 2'd0) && (op1[5:4] != 2'd0)) begin
            p.state = S_SEP;
            p.code  = TOK_SEP;
            p.last  = 1'b0;
            done    = 1'b1;
         end else begin
            ph = S_OPD1;
            st = 4'd0;
         end
      end
      if (!done && ph == S_OPD1) begin
         s = find_step(op1, st);
         if (!s[3]) begin
            p.state = S_OPD1;
            p.step  = s[2:0];
            p.code  = step_code(op1, s[2:0]);
            p.opd   = 1'b1;
            p.last  = 1'b0;
         end
      end
      return p;
   endfunction

   // Descriptor FIFO storage and pointers
   logic [TAG_W-1:0] r_tag_mem [DEPTH];
   logic [5:0]       r_op0_mem [DEPTH];
   logic [5:0]       r_op1_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;

   // Working descriptor and registered token outputs
   state_t           r_state;
   logic [2:0]       r_step;
   logic [TAG_W-1:0] r_tag;
   logic [5:0]       r_op0;
   logic [5:0]       r_op1;
   logic             r_tok_valid;
   logic [3:0]       r_tok_code;
   logic             r_tok_opd;
   logic             r_tok_last;

   logic             w_push;
   logic             w_accept;
   logic             w_pop;
   logic [AW-1:0]    w_rd_nxt;
   logic             w_have_head;
   logic [TAG_W-1:0] w_head_tag;
   logic [5:0]       w_head_op0;
   logic [5:0]       w_head_op1;
   logic             w_have_next;
   logic [TAG_W-1:0] w_next_tag;
   logic [5:0]       w_next_op0;
   logic [5:0]       w_next_op1;
   plan_t            w_plan;

   // No full-bypass: a full FIFO refuses a push even if EOL pops this cycle
   assign in_ready = (r_count < FULL_CNT);
   assign w_push   = in_valid & in_ready & ~flush;
   assign w_accept = r_tok_valid & tok_ready;
   assign w_pop    = w_accept & (r_state == S_EOL) & ~flush;
   assign w_rd_nxt = r_rd_ptr + AW'(1);

   // From IDLE the head is either a stored entry or the descriptor being
   // pushed right now, which gives MNEM one cycle after the push.
   assign w_have_head = (r_count != '0) | w_push;
   assign w_head_tag  = (r_count != '0) ? r_tag_mem[r_rd_ptr] : in_tag;
   assign w_head_op0  = (r_count != '0) ? r_op0_mem[r_rd_ptr] : in_op0;
   assign w_head_op1  = (r_count != '0) ? r_op1_mem[r_rd_ptr] : in_op1;

   // After the EOL pop the next instruction is the entry behind the head,
   // or the descriptor arriving in the same cycle if nothing else is queued.
   assign w_have_next = (r_count > ONE_CNT) | w_push;
   assign w_next_tag  = (r_count > ONE_CNT) ? r_tag_mem[w_rd_nxt] : in_tag;
   assign w_next_op0  = (r_count > ONE_CNT) ? r_op0_mem[w_rd_nxt] : in_op0;
   assign w_next_op1  = (r_count > ONE_CNT) ? r_op1_mem[w_rd_nxt] : in_op1;

   // Plan the token that follows the current one once it is accepted
   always_comb begin
      w_plan = plan_next(r_op0, r_op1, S_OPD0, 4'd0);
      case (r_state)
         S_OPD0:  w_plan = plan_next(r_op0, r_op1, S_OPD0, {1'b0, r_step} + 4'd1);
         S_SEP:   w_plan = plan_next(r_op0, r_op1, S_OPD1, 4'd0);
         S_OPD1:  w_plan = plan_next(r_op0, r_op1, S_OPD1, {1'b0, r_step} + 4'd1);
         default: w_plan = plan_next(r_op0, r_op1, S_OPD0, 4'd0);
      endcase
   end

   // FIFO payload write; validity is tracked by the pointers alone
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_tag_mem[r_wr_ptr] <= in_tag;
         r_op0_mem[r_wr_ptr] <= in_op0;
         r_op1_mem[r_wr_ptr] <= in_op1;
      end
   end

   // FIFO pointers and occupancy; flush empties the queue
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= w_rd_nxt;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + ONE_CNT;
            2'b01:   r_count <= r_count - ONE_CNT;
            default: r_count <= r_count;
         endcase
      end
   end

   // Sequencer FSM with registered token outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= S_IDLE;
         r_step      <= 3'd0;
         r_tag       <= '0;
         r_op0       <= 6'd0;
         r_op1       <= 6'd0;
         r_tok_valid <= 1'b0;
         r_tok_code  <= 4'd0;
         r_tok_opd   <= 1'b0;
         r_tok_last  <= 1'b0;
      end else if (flush) begin
         r_state     <= S_IDLE;
         r_step      <= 3'd0;
         r_tok_valid <= 1'b0;
         r_tok_code  <= 4'd0;
         r_tok_opd   <= 1'b0;
         r_tok_last  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_have_head) begin
                  r_tag       <= w_head_tag;
                  r_op0       <= w_head_op0;
                  r_op1       <= w_head_op1;
                  r_state     <= S_MNEM;
                  r_step      <= 3'd0;
                  r_tok_valid <= 1'b1;
                  r_tok_code  <= TOK_MNEM;
                  r_tok_opd   <= 1'b0;
                  r_tok_last  <= 1'b0;
               end
            end
            S_EOL: begin
               if (w_accept) begin
                  if (w_have_next) begin
                     r_tag       <= w_next_tag;
                     r_op0       <= w_next_op0;
                     r_op1       <= w_next_op1;
                     r_state     <= S_MNEM;
                     r_step      <= 3'd0;
                     r_tok_valid <= 1'b1;
                     r_tok_code  <= TOK_MNEM;
                     r_tok_opd   <= 1'b0;
                     r_tok_last  <= 1'b0;
                  end else begin
                     r_state     <= S_IDLE;
                     r_step      <= 3'd0;
                     r_tok_valid <= 1'b0;
                     r_tok_code  <= 4'd0;
                     r_tok_opd   <= 1'b0;
                     r_tok_last  <= 1'b0;
                  end
               end
            end
            default: begin
               if (w_accept) begin
                  r_state    <= w_plan.state;
                  r_step     <= w_plan.step;
                  r_tok_code <= w_plan.code;
                  r_tok_opd  <= w_plan.opd;
                  r_tok_last <= w_plan.last;
               end
            end
         endcase
      end
   end

   assign tok_valid = r_tok_valid;
   assign tok_code  = r_tok_code;
   assign tok_opd   = r_tok_opd;
   assign tok_tag   = r_tag;
   assign tok_last  = r_tok_last;
   assign dbg_state = r_state;

endmodule
